bp_update_queue: RTL and testbench
==================================

Name: bp_update_queue

Overview:
- Sits between the retire stage and the branch predictor / BTB.
- Accepts up to `RETIRE_WIDTH` retired-branch outcomes per cycle, in program order.
- Buffers them in a circular FIFO and presents exactly one training update per cycle to the predictor over a valid/ready handshake.
- Decouples superscalar retire bandwidth from the single-ported update path of the branch history and pattern tables.

Parameters:
- `RETIRE_WIDTH`, default 2: retire lanes sampled per cycle.
- `DEPTH`, default 8: queue entries; power of two, DEPTH >= RETIRE_WIDTH.
- `CNT_W`, default $clog2(DEPTH)+1: width of count / free-slot values.

Ports:
- `clock`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `retire_valid`  input  RETIRE_WIDTH  per-lane retired-branch strobe; lane 0 is oldest.
- `retire_pc`  input  RETIRE_WIDTH x 32  branch PC per lane.
- `retire_taken`  input  RETIRE_WIDTH  resolved direction per lane.
- `retire_target`  input  RETIRE_WIDTH x 32  resolved target per lane.
- `free_slots`  output  CNT_W  entries available this cycle; retire must not present more valid lanes than this.
- `upd_valid`  output  1  head entry valid.
- `upd_pc`  output  32  head PC.
- `upd_taken`  output  1  head direction.
- `upd_target`  output  32  head target.
- `upd_ready`  input  1  predictor accepts head this cycle.
- `overflow`  output  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high):
  - head = tail = count = 0; overflow = 0; upd_valid = 0; free_slots = DEPTH.
  - Stored entry payloads are don't-care after reset.
- Enqueue:
  - Valid lanes are compacted in lane order; sparse masks are legal, e.g. 2'b10 enqueues lane 1 only.
  - The k-th valid lane is written at (tail + k) mod DEPTH.
  - tail advances by popcount(retire_valid), wrapping mod DEPTH.
  - Entries become visible at the head the cycle after the write. There is no same-cycle bypass, so minimum enqueue-to-upd_valid latency is 1 cycle.
- Dequeue:
  - Occurs when upd_valid && upd_ready. head advances by 1 with wrap.
  - upd_* are driven combinationally from the head entry. They must hold stable while upd_valid && !upd_ready.
  - upd_valid = (count != 0).
- Count:
  - count_next = count + enq_n − deq.
  - Enqueue and dequeue in the same cycle are both allowed.
- free_slots:
  - free_slots = DEPTH − count, from registered state only.
  - A dequeue in the current cycle does not raise free_slots until the next cycle. There is no combinational path from upd_ready to free_slots.
- Full (count == DEPTH):
  - free_slots = 0; retire is expected to stall.
  - Any valid lane presented while full is dropped.
- Overflow:
  - If popcount(retire_valid) > free_slots, lanes in excess of free_slots are dropped, highest lane first.
  - The first free_slots valid lanes are still enqueued.
  - overflow sets the next cycle and stays set until reset.
- Empty (count == 0): upd_valid = 0; upd_ready is ignored; head does not move.
- Wrap-around: a multi-lane enqueue may straddle index DEPTH−1 → 0; entries stay contiguous mod DEPTH.
- Reset mid-operation: all queued entries are discarded. No update is issued in the reset cycle or the cycle after.
- No flush port: only retired (non-speculative) branches enter, so the queue is never squashed.

Decomposition:
- Shared package (sys_defs.svh):
  - `BP_UPDATE_PACKET` struct {pc, taken, target}, reused by the predictor's update port.
  - `` `RETIRE_WIDTH `` and `` `BPQ_DEPTH `` macros.
- One natural sub-module: `bp_update_compact`, combinational.
  - Input: retire_valid plus the payloads.
  - Outputs: lane-compacted packets, popcount enq_n, and the overflow-clipped write mask.
- The FIFO state lives in `bp_update_queue`.

Test Plan:
- Reset then idle → upd_valid=0, free_slots=8, overflow=0 across 5 cycles.
- Lanes 2'b11, pc0=0x100/T, pc1=0x104/NT, upd_ready=1 → next cycle upd_pc=0x100 taken=1; following cycle upd_pc=0x104 taken=0; then upd_valid=0.
- Sparse mask 2'b10, pc1=0x200 target 0x240 → single entry; upd_pc=0x200, upd_target=0x240; count returns to 0 after one accept.
- upd_ready=0, enqueue 2 lanes/cycle for 4 cycles:
  - → free_slots 8,6,4,2,0; upd_* stay at the first PC.
  - Raise ready → 8 updates drain in order, with head wrapping 7→0.
- At count=7, present 2'b11 (pcs 0x300, 0x304) → 0x300 enqueued, 0x304 dropped; overflow=1 next cycle and it persists.
- At count=7, wrap straddle (tail=7), simultaneous enqueue 1 + dequeue 1 → count stays 7; entry lands at index 7 and the next at index 0, in order.
- Assert reset with 5 entries queued → next cycle upd_valid=0, free_slots=8.

Source files
------------

// File: rtl/bp_update_queue_pkg.sv
// Shared definitions for the branch-predictor training update queue.
// Contents:
//   BPQ_RETIRE_WIDTH  default number of retire lanes sampled per cycle
//   BPQ_DEPTH         default queue depth (power of two)
//   bp_update_packet_t  one training update {pc, taken, target}; the
//                       predictor's update port uses the same struct.
package bp_update_queue_pkg;

  localparam int BPQ_RETIRE_WIDTH = 2;
  localparam int BPQ_DEPTH        = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_update_packet_t;

endpackage

// File: rtl/bp_update_queue_compact.sv
// Combinational lane compaction for the update queue.
// Packs the valid retire lanes, in lane order, into the low slots of
// packets[], clipping to the number of free queue entries.
// Ports:
//   retire_valid/pc/taken/target  per-lane retired-branch outcome, lane 0 oldest
//   free_slots                    entries the queue can still accept this cycle
//   packets                       compacted packets; slot k holds the k-th accepted lane
//   write_mask                    per-lane mask of lanes actually accepted
//   enq_n                         number of accepted lanes (popcount of write_mask)
//   drop                          at least one valid lane did not fit
module bp_update_queue_compact
  import bp_update_queue_pkg::*;
#(
  parameter int RETIRE_WIDTH = BPQ_RETIRE_WIDTH,
  parameter int CNT_W        = $clog2(BPQ_DEPTH) + 1
) (
  input  logic [RETIRE_WIDTH-1:0]       retire_valid,
  input  logic [RETIRE_WIDTH-1:0][31:0] retire_pc,
  input  logic [RETIRE_WIDTH-1:0]       retire_taken,
  input  logic [RETIRE_WIDTH-1:0][31:0] retire_target,
  input  logic [CNT_W-1:0]              free_slots,
  output bp_update_packet_t             packets [RETIRE_WIDTH],
  output logic [RETIRE_WIDTH-1:0]       write_mask,
  output logic [CNT_W-1:0]              enq_n,
  output logic                          drop
);

  // rank[i] = number of valid lanes below lane i, i.e. its compacted slot.
  logic [CNT_W-1:0] rank [RETIRE_WIDTH];
  logic [CNT_W-1:0] raw_n;

  always_comb begin
    raw_n      = '0;
    enq_n      = '0;
    write_mask = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      rank[i]       = raw_n;
      // Older lanes claim free entries first, so excess is dropped from
      // the highest lane downwards.
      write_mask[i] = retire_valid[i] && (raw_n < free_slots);
      raw_n         = raw_n + CNT_W'(retire_valid[i]);
      enq_n         = enq_n + CNT_W'(write_mask[i]);
    end
    drop = (raw_n > free_slots);

    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      packets[j] = '0;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (write_mask[i] && (rank[i] == CNT_W'(j))) begin
          packets[j] = '{pc: retire_pc[i], taken: retire_taken[i], target: retire_target[i]};
        end
      end
    end
  end

endmodule

// File: rtl/bp_update_queue.sv
// Branch-predictor training update queue.
// Buffers up to RETIRE_WIDTH retired-branch outcomes per cycle in a circular
// FIFO and offers one update per cycle to the predictor.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   retire_*             per-lane retired-branch outcomes, lane 0 oldest
//   free_slots           DEPTH - count, from registered state only
//   upd_valid/pc/taken/target, upd_ready   predictor update handshake
//   overflow             sticky: a valid lane was dropped for lack of space
//
// Handshake: an update transfers on a rising clock edge where
// upd_valid && upd_ready. While upd_valid && !upd_ready the upd_* payload
// holds stable. upd_ready is ignored while upd_valid is low, and nothing
// from upd_ready reaches free_slots combinationally.
module bp_update_queue
  import bp_update_queue_pkg::*;
#(
  parameter int RETIRE_WIDTH = BPQ_RETIRE_WIDTH,
  parameter int DEPTH        = BPQ_DEPTH,
  parameter int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [RETIRE_WIDTH-1:0]       retire_valid,
  input  logic [RETIRE_WIDTH-1:0][31:0] retire_pc,
  input  logic [RETIRE_WIDTH-1:0]       retire_taken,
  input  logic [RETIRE_WIDTH-1:0][31:0] retire_target,
  output logic [CNT_W-1:0]              free_slots,
  output logic                          upd_valid,
  output logic [31:0]                   upd_pc,
  output logic                          upd_taken,
  output logic [31:0]                   upd_target,
  input  logic                          upd_ready,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  bp_update_packet_t       mem [DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        count;

  bp_update_packet_t       packets [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] write_mask;
  logic [CNT_W-1:0]        enq_n;
  logic                    drop;
  logic                    any_write;
  logic                    deq;

  assign free_slots = CNT_W'(DEPTH) - count;

  bp_update_queue_compact #(
    .RETIRE_WIDTH (RETIRE_WIDTH),
    .CNT_W        (CNT_W)
  ) u_compact (
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .retire_taken  (retire_taken),
    .retire_target (retire_target),
    .free_slots    (free_slots),
    .packets       (packets),
    .write_mask    (write_mask),
    .enq_n         (enq_n),
    .drop          (drop)
  );

  assign any_write = |write_mask;

  // Masked during the reset cycle so stale entries are never offered.
  assign upd_valid  = (count != '0) && !reset;
  assign deq        = upd_valid && upd_ready;
  assign upd_pc     = mem[head].pc;
  assign upd_taken  = mem[head].taken;
  assign upd_target = mem[head].target;

  // Payload storage carries no reset; entries are only read once counted.
  // Pointer width is log2(DEPTH), so tail + k wraps modulo DEPTH for free.
  always_ff @(posedge clock) begin
    if (any_write) begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (CNT_W'(k) < enq_n) begin
          mem[tail + PTR_W'(k)] <= packets[k];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      tail  <= tail + enq_n[PTR_W-1:0];
      count <= count + enq_n - CNT_W'(deq);
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue.
module tb_bp_update_queue;

  localparam int RW    = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic                clock;
  logic                reset;
  logic [RW-1:0]       retire_valid;
  logic [RW-1:0][31:0] retire_pc;
  logic [RW-1:0]       retire_taken;
  logic [RW-1:0][31:0] retire_target;
  logic [CNT_W-1:0]    free_slots;
  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic                upd_taken;
  logic [31:0]         upd_target;
  logic                upd_ready;
  logic                overflow;

  bp_update_queue #(
    .RETIRE_WIDTH (RW),
    .DEPTH        (DEPTH),
    .CNT_W        (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .retire_taken  (retire_taken),
    .retire_target (retire_target),
    .free_slots    (free_slots),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_ready     (upd_ready),
    .overflow      (overflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  // Reference model: the queue contents are exactly exp_q; entries accepted
  // this cycle wait in pend_q until the clock edge makes them visible.
  logic [64:0] exp_q[$];
  logic [64:0] pend_q[$];
  logic        pend_drop = 1'b0;
  logic        model_ovf = 1'b0;
  bit          mon_en    = 1'b0;
  int          errors    = 0;
  int          checks    = 0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Commit at each clock edge: reset wipes the model, otherwise this cycle's
  // accepted entries become visible and a drop latches the sticky flag.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        exp_q.delete();
        model_ovf = 1'b0;
      end else begin
        foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
        if (pend_drop) model_ovf = 1'b1;
      end
      pend_q.delete();
      pend_drop = 1'b0;
    end
  end

  // Monitor: sample on the falling edge, compare against the model head,
  // and retire the head when the handshake will complete at the next edge.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        check("free_slots", 65'(free_slots), 65'(DEPTH - exp_q.size()));
        check("overflow", 65'(overflow), 65'(model_ovf));
        if (reset) begin
          check("valid_in_reset", 65'(upd_valid), 65'd0);
        end else begin
          check("upd_valid", 65'(upd_valid), 65'(exp_q.size() != 0));
          if (exp_q.size() != 0) begin
            check("upd_pkt", {upd_pc, upd_taken, upd_target}, exp_q[0]);
            if (upd_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic t0,
                       input logic [31:0] g0, input logic [31:0] pc1, input logic t1,
                       input logic [31:0] g1, input logic rdy, input logic rst = 1'b0);
    int free;
    int n;
    int raw;
    @(posedge clock);
    #1;
    reset            = rst;
    retire_valid     = v;
    retire_pc[0]     = pc0;
    retire_taken[0]  = t0;
    retire_target[0] = g0;
    retire_pc[1]     = pc1;
    retire_taken[1]  = t1;
    retire_target[1] = g1;
    upd_ready        = rdy;
    if (!rst) begin
      free = DEPTH - exp_q.size();
      n    = 0;
      raw  = 0;
      for (int i = 0; i < RW; i++) begin
        if (v[i]) begin
          raw++;
          if (n < free) begin
            pend_q.push_back((i == 0) ? {pc0, t0, g0} : {pc1, t1, g1});
            n++;
          end
        end
      end
      if (raw > free) pend_drop = 1'b1;
    end
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int c = 0; c < cycles; c++) drive(2'b00, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  // Two-lane enqueue of consecutive PCs starting at base.
  task automatic enq2(input logic [31:0] base, input logic rdy);
    drive(2'b11, base, 1'b1, base + 32'h40, base + 32'h4, 1'b0, base + 32'h44, rdy);
  endtask

  task automatic rand_cycle(input bit allow_ovf);
    logic [1:0] v;
    int         free;
    free = DEPTH - exp_q.size();
    v    = 2'($urandom_range(0, 3));
    if (!allow_ovf) begin
      if (free == 0) v = 2'b00;
      else if (free == 1 && v == 2'b11) v = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    end
    drive(v, {$urandom_range(0, 32'hFFFF), 2'b00}, 1'($urandom_range(0, 1)), $urandom,
             {$urandom_range(0, 32'hFFFF), 2'b00}, 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 3) != 0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    retire_valid  = '0;
    retire_pc     = '0;
    retire_taken  = '0;
    retire_target = '0;
    upd_ready     = 1'b0;

    do_reset(3);
    idle(1, 1'b1);
    mon_en = 1'b1;

    // Reset then idle.
    idle(5, 1'b1);

    // Two lanes in one cycle drain in lane order.
    drive(2'b11, 32'h100, 1'b1, 32'h180, 32'h104, 1'b0, 32'h108, 1'b1);
    idle(3, 1'b1);

    // Sparse mask: lane 1 only.
    drive(2'b10, 32'h0, 1'b0, 32'h0, 32'h200, 1'b1, 32'h240, 1'b1);
    idle(2, 1'b1);

    // Fill with ready low, then drain across the wrap point.
    for (int k = 0; k < 4; k++) enq2(32'h1000 + 32'(k * 8), 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);

    // Overflow: count 7, two lanes presented, lane 1 dropped.
    do_reset(1);
    for (int k = 0; k < 3; k++) enq2(32'h2000 + 32'(k * 8), 1'b0);
    drive(2'b01, 32'h2100, 1'b1, 32'h2140, 0, 0, 0, 1'b0);
    drive(2'b11, 32'h300, 1'b1, 32'h340, 32'h304, 1'b0, 32'h344, 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);
    idle(3, 1'b0);

    // Wrap straddle: tail at 7, simultaneous enqueue and dequeue.
    do_reset(1);
    for (int k = 0; k < 3; k++) enq2(32'h3000 + 32'(k * 8), 1'b0);
    drive(2'b01, 32'h3100, 1'b0, 32'h3140, 0, 0, 0, 1'b0);
    drive(2'b01, 32'h400, 1'b1, 32'h440, 0, 0, 0, 1'b1);
    drive(2'b01, 32'h404, 1'b0, 32'h444, 0, 0, 0, 1'b0);
    idle(12, 1'b1);

    // Reset with five entries queued.
    enq2(32'h5000, 1'b0);
    enq2(32'h5008, 1'b0);
    drive(2'b01, 32'h5010, 1'b1, 32'h5050, 0, 0, 0, 1'b0);
    do_reset(1);
    idle(3, 1'b1);

    // Random traffic honouring free_slots, then with overflow allowed.
    for (int c = 0; c < 400; c++) rand_cycle(1'b0);
    do_reset(1);
    for (int c = 0; c < 200; c++) rand_cycle(1'b1);

    // Bounded drain.
    begin
      int budget;
      budget = 40;
      while ((exp_q.size() != 0 || pend_q.size() != 0) && budget > 0) begin
        idle(1, 1'b1);
        budget--;
      end
      checks++;
      if (exp_q.size() != 0 || pend_q.size() != 0) begin
        errors++;
        $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
      end
    end
    idle(2, 1'b1);
    @(negedge clock);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
